// File: rtl/arb_pkg.sv
// Shared types for the two-port SDRAM arbiter.
//   NumPorts    : number of requesters sharing the SDRAM master
//   arb_state_e : arbiter FSM states
package arb_pkg;

  localparam int unsigned NumPorts = 2;

  typedef enum logic [2:0] {
    StIdle,
    StGrant0,
    StGrant1,
    StWaitRd0,
    StWaitRd1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin choice between two requesters, purely combinational.
//   req   : per-requester request (read | write)
//   last  : index of the requester served most recently
//   grant : index of the requester to serve; only meaningful when req != 0
module rr_pick
  import arb_pkg::*;
(
  input  logic [NumPorts-1:0] req,
  input  logic                last,
  output logic                grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;  // tie: whoever was not served last
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one Avalon-MM SDRAM master between requesters m0 and m1 with at most
// one transfer outstanding.
//   clk, rst_n          : clock, asynchronous active-low reset
//   m0_* / m1_*         : requester slave ports (address, read, write, writedata in;
//                         waitrequest, readdata, readdatavalid out)
//   sdram_*             : downstream master port
module sdram_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m1_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              sdram_waitrequest,
  output logic [ADDR_W-1:0] sdram_address,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic [DATA_W-1:0] sdram_writedata,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_readdatavalid
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [NumPorts-1:0] req;
  logic       pick;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_pick u_rr_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;  // m0 wins the first tie
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req) state_d = pick ? StGrant1 : StGrant0;
      end
      StGrant0: begin
        // Read wins when both are raised, so it follows the read path.
        if (m0_read && !sdram_waitrequest) begin
          state_d = StWaitRd0;
          last_d  = 1'b0;
        end else if (m0_write && !sdram_waitrequest) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end else if (!m0_read && !m0_write) begin
          state_d = StIdle;
        end
      end
      StGrant1: begin
        if (m1_read && !sdram_waitrequest) begin
          state_d = StWaitRd1;
          last_d  = 1'b1;
        end else if (m1_write && !sdram_waitrequest) begin
          state_d = StIdle;
          last_d  = 1'b1;
        end else if (!m1_read && !m1_write) begin
          state_d = StIdle;
        end
      end
      StWaitRd0, StWaitRd1: begin
        if (sdram_readdatavalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Forwarding is combinational so a granted requester sees sdram_waitrequest directly.
  always_comb begin
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    sdram_address    = '0;
    sdram_read       = 1'b0;
    sdram_write      = 1'b0;
    sdram_writedata  = '0;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    unique case (state_q)
      StGrant0: begin
        m0_waitrequest  = sdram_waitrequest;
        sdram_address   = m0_address;
        sdram_read      = m0_read;
        sdram_write     = m0_write;
        sdram_writedata = m0_writedata;
      end
      StGrant1: begin
        m1_waitrequest  = sdram_waitrequest;
        sdram_address   = m1_address;
        sdram_read      = m1_read;
        sdram_write     = m1_write;
        sdram_writedata = m1_writedata;
      end
      StWaitRd0: m0_readdatavalid = sdram_readdatavalid;
      StWaitRd1: m1_readdatavalid = sdram_readdatavalid;
      default: ;
    endcase
  end

  assign m0_readdata = sdram_readdata;
  assign m1_readdata = sdram_readdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter. Stimulus pushes expected SDRAM transfers and
// expected read returns into queues; a negedge monitor pops and compares them.
module tb_sdram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    logic          port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } rdret_t;

  logic          clk, rst_n;
  logic          m0_waitrequest, m1_waitrequest;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          sdram_waitrequest;
  logic [AW-1:0] sdram_address;
  logic          sdram_read, sdram_write;
  logic [DW-1:0] sdram_writedata, sdram_readdata;
  logic          sdram_readdatavalid;

  int n_checks = 0;
  int n_err    = 0;

  xfer_t  exp_xfer[$];
  rdret_t exp_rd[$];
  xfer_t  ex;
  rdret_t er;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .m0_waitrequest      (m0_waitrequest),
    .m0_address          (m0_address),
    .m0_read             (m0_read),
    .m0_write            (m0_write),
    .m0_writedata        (m0_writedata),
    .m0_readdata         (m0_readdata),
    .m0_readdatavalid    (m0_readdatavalid),
    .m1_waitrequest      (m1_waitrequest),
    .m1_address          (m1_address),
    .m1_read             (m1_read),
    .m1_write            (m1_write),
    .m1_writedata        (m1_writedata),
    .m1_readdata         (m1_readdata),
    .m1_readdatavalid    (m1_readdatavalid),
    .sdram_waitrequest   (sdram_waitrequest),
    .sdram_address       (sdram_address),
    .sdram_read          (sdram_read),
    .sdram_write         (sdram_write),
    .sdram_writedata     (sdram_writedata),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0;
  endtask

  task automatic push_x(input logic p, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    xfer_t x;
    x.port = p; x.rd = rd; x.wr = wr; x.addr = a; x.data = d;
    exp_xfer.push_back(x);
  endtask

  task automatic push_r(input logic p, input logic [DW-1:0] d);
    rdret_t r;
    r.port = p; r.data = d;
    exp_rd.push_back(r);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr01"}, {62'd0, m1_waitrequest, m0_waitrequest}, 64'h3);
    check({tag, "_rdwr"}, {62'd0, sdram_read, sdram_write}, 64'h0);
    check({tag, "_addr_data"}, {sdram_address, sdram_writedata}, 64'h0);
    check({tag, "_rdv"}, {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'h0);
  endtask

  // Monitor: compares every accepted SDRAM transfer and every read return.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((sdram_read || sdram_write) && !sdram_waitrequest) begin
        if (exp_xfer.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_xfer: got rd=%0b wr=%0b addr=0x%0h expected none",
                   sdram_read, sdram_write, sdram_address);
        end else begin
          ex = exp_xfer.pop_front();
          check("xfer_grant", {62'd0, m1_waitrequest, m0_waitrequest},
                ex.port ? 64'h1 : 64'h2);
          check("xfer_rdwr", {62'd0, sdram_read, sdram_write}, {62'd0, ex.rd, ex.wr});
          check("xfer_addr", 64'(sdram_address), 64'(ex.addr));
          check("xfer_data", 64'(sdram_writedata), 64'(ex.data));
        end
      end
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (exp_rd.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_rdv: got m0=%0b m1=%0b expected none",
                   m0_readdatavalid, m1_readdatavalid);
        end else begin
          er = exp_rd.pop_front();
          check("rdv_port", {62'd0, m1_readdatavalid, m0_readdatavalid},
                er.port ? 64'h2 : 64'h1);
          check("rdv_data", 64'(er.port ? m1_readdata : m0_readdata), 64'(er.data));
        end
      end
    end
  end

  initial begin
    rst_n = 0;
    clear_reqs();
    sdram_waitrequest = 0; sdram_readdata = '0; sdram_readdatavalid = 0;
    step(); step();
    check_idle_outputs("reset");
    rst_n = 1;
    step();

    // m0 read 0x100, two waitrequest cycles, data three cycles after acceptance
    sdram_waitrequest = 1;
    m0_address = 32'h100; m0_read = 1;
    push_x(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    push_r(1'b0, 32'hDEADBEEF);
    check("arb_latency_idle", {63'd0, sdram_read}, 64'h0);
    step();
    check("grant0_read", {63'd0, sdram_read}, 64'h1);
    check("grant0_stall", {63'd0, m0_waitrequest}, 64'h1);
    step();
    sdram_waitrequest = 0;
    step();
    m0_read = 0;
    check("waitrd0_outputs", {61'd0, m0_waitrequest, sdram_read, sdram_write}, 64'h4);
    step(); step();
    sdram_readdata = 32'hDEADBEEF; sdram_readdatavalid = 1;
    step();
    sdram_readdatavalid = 0;
    check_idle_outputs("after_read");

    // Both write continuously from reset: m0, m1, m0, m1
    rst_n = 0;
    step();
    rst_n = 1;
    m0_address = 32'h0;  m0_writedata = 32'hA0; m0_write = 1;
    m1_address = 32'h40; m1_writedata = 32'hB1; m1_write = 1;
    push_x(1'b0, 1'b0, 1'b1, 32'h0, 32'hA0);
    push_x(1'b1, 1'b0, 1'b1, 32'h40, 32'hB1);
    push_x(1'b0, 1'b0, 1'b1, 32'h0, 32'hA0);
    push_x(1'b1, 1'b0, 1'b1, 32'h40, 32'hB1);
    repeat (8) step();
    clear_reqs();
    step(); step();

    // m1 write waits behind outstanding m0 read
    m0_address = 32'h200; m0_read = 1;
    push_x(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    push_r(1'b0, 32'h55AA);
    push_x(1'b1, 1'b0, 1'b1, 32'h80, 32'h1234);
    step();
    step();
    m0_read = 0;
    m1_address = 32'h80; m1_writedata = 32'h1234; m1_write = 1;
    step(); step();
    check("no_write_in_waitrd", {63'd0, sdram_write}, 64'h0);
    sdram_readdata = 32'h55AA; sdram_readdatavalid = 1;
    step();
    sdram_readdatavalid = 0;
    check("idle_before_m1", {63'd0, sdram_write}, 64'h0);
    step();
    check("m1_write_granted", {63'd0, sdram_write}, 64'h1);
    check("m1_write_addr", 64'(sdram_address), 64'h80);
    step();
    clear_reqs();
    step();

    // m0 drops in GRANT0 before acceptance; last stays m1 so next tie goes to m0
    sdram_waitrequest = 1;
    m0_address = 32'h300; m0_write = 1; m0_writedata = 32'h77;
    step();
    check("grant0_pending", {62'd0, sdram_write, m0_waitrequest}, 64'h3);
    m0_write = 0;
    step();
    check_idle_outputs("drop_idle");
    sdram_waitrequest = 0;
    m0_address = 32'h8;  m0_writedata = 32'h11; m0_write = 1;
    m1_address = 32'h48; m1_writedata = 32'h22; m1_write = 1;
    push_x(1'b0, 1'b0, 1'b1, 32'h8, 32'h11);
    step();
    step();
    clear_reqs();
    step();

    // Stray readdatavalid in IDLE
    sdram_readdata = 32'hCAFE0001; sdram_readdatavalid = 1;
    #2;
    check("readdata_pass", {m1_readdata, m0_readdata}, {32'hCAFE0001, 32'hCAFE0001});
    step(); step();
    sdram_readdatavalid = 0;
    check_idle_outputs("stray_rdv");

    // Reset pulsed in WAITRD1, late data dropped, next tie goes to m0
    m1_address = 32'h500; m1_read = 1;
    push_x(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    step();
    step();
    m1_read = 0;
    rst_n = 0;
    #1;
    check_idle_outputs("async_reset");
    step();
    rst_n = 1;
    sdram_readdatavalid = 1; sdram_readdata = 32'hBAD;
    step();
    sdram_readdatavalid = 0;
    m0_address = 32'h10; m0_writedata = 32'h33; m0_write = 1;
    m1_address = 32'h50; m1_writedata = 32'h44; m1_write = 1;
    push_x(1'b0, 1'b0, 1'b1, 32'h10, 32'h33);
    step();
    step();
    clear_reqs();
    step(); step();

    check("xfer_queue_empty", 64'(exp_xfer.size()), 64'h0);
    check("rd_queue_empty", 64'(exp_rd.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
